// File: rtl/soc_decerr_slave.sv
// soc_decerr_slave: default AXI4 slave for unmapped addresses.
// Every write gets a DECERR B response and every read gets DECERR R beats.
// The write and read channels are independent, and each holds one burst at a time.
// Optional build macro: DECERR_SLAVE_LOG_EN adds an error counter and a last-address log.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1. A valid output stays high, with stable
// payload, until that transfer. Ready outputs come only from FSM state and
// never depend on the matching valid input.
module soc_decerr_slave #(
  parameter int                   IdWidth   = 5,
  parameter int                   DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEC0_DEC0_DEC0_DEC0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // write address
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [63:0]          aw_addr_i,
  input  logic [7:0]           aw_len_i,
  // write data
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  // write response
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  // read address
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [63:0]          ar_addr_i,
  input  logic [7:0]           ar_len_i,
  // read data
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
`ifdef DECERR_SLAVE_LOG_EN
  output logic [31:0]          err_cnt_o,
  output logic [63:0]          err_addr_o,
`endif
  // debug view of the FSM states
  output logic [1:0]           dbg_w_state_o,
  output logic                 dbg_r_state_o
);

  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   w_id_q, r_id_q;
  logic [7:0]           cnt_q, len_q;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;
  assign b_hs  = b_valid_o & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  assign b_id_o        = w_id_q;
  assign b_resp_o      = RespDecerr;
  assign r_id_o        = r_id_q;
  assign r_data_o      = RespData;
  assign r_resp_o      = RespDecerr;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;

  // Write FSM state register. The ID is captured on AW acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) w_id_q <= aw_id_i;
    end
  end

  // Write FSM next state and channel readies/valids.
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM state register, ID and burst length capture, and beat counter.
  // The counter stops on the last beat, so a 256-beat burst never wraps it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q <= ar_id_i;
        cnt_q  <= '0;
        len_q  <= ar_len_i;
      end else if (r_hs && !r_last_o) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Read FSM next state, readies/valids, and the last-beat flag.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (cnt_q == len_q);
        if (r_ready_i && r_last_o) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

`ifdef DECERR_SLAVE_LOG_EN
  logic [32:0] cnt_sum;
  assign cnt_sum = {1'b0, err_cnt_o} + {32'd0, aw_hs} + {32'd0, ar_hs};

  // Error log: count accepted requests with saturation and keep the latest address.
  // When AW and AR arrive together, the AW address is the one kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else begin
      err_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      if (aw_hs)      err_addr_o <= aw_addr_i;
      else if (ar_hs) err_addr_o <= ar_addr_i;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{aw_len_i, w_hs, b_hs};
`else
  logic unused_inputs;
  assign unused_inputs = ^{aw_len_i, aw_addr_i, ar_addr_i, w_hs, b_hs};
`endif

endmodule

// File: tb/tb_soc_decerr_slave.sv
// tb_soc_decerr_slave: directed testbench for soc_decerr_slave.
// Inputs are driven on the falling clock edge and outputs are checked there too.
// The build macro DECERR_SLAVE_LOG_EN enables the log-port checks.
module tb_soc_decerr_slave;

  localparam logic [63:0] RESP_DATA = 64'hDEC0_DEC0_DEC0_DEC0;

  logic        clk, rst;
  logic        aw_valid, aw_ready;
  logic [4:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid, w_ready, w_last;
  logic        b_valid, b_ready;
  logic [4:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [4:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid, r_ready;
  logic [4:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [1:0]  dbg_w_state;
  logic        dbg_r_state;
`ifdef DECERR_SLAVE_LOG_EN
  logic [31:0] err_cnt;
  logic [63:0] err_addr;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  soc_decerr_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .aw_addr_i(aw_addr), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
`ifdef DECERR_SLAVE_LOG_EN
    .err_cnt_o(err_cnt), .err_addr_o(err_addr),
`endif
    .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0;
    w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0;
    r_ready = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_aw_ready"}, aw_ready, 1);
    chk({tag, "_ar_ready"}, ar_ready, 1);
    chk({tag, "_w_ready"},  w_ready, 0);
    chk({tag, "_b_valid"},  b_valid, 0);
    chk({tag, "_r_valid"},  r_valid, 0);
    chk({tag, "_r_last"},   r_last, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---- reset values
    chk_idle("reset");
    chk("reset_b_id", b_id, 0);
    chk("reset_r_id", r_id, 0);
    chk("reset_w_state", dbg_w_state, 0);
    chk("reset_r_state", dbg_r_state, 0);
    rst = 1'b0;

    // ---- W presented before AW is not taken
    @(negedge clk);
    w_valid = 1; w_last = 1; b_ready = 1;
    @(negedge clk);
    chk("early_w_ready", w_ready, 0);
    chk("early_w_b_valid", b_valid, 0);
    chk("early_w_aw_ready", aw_ready, 1);

    // ---- single write, id 5'h13
    aw_valid = 1; aw_id = 5'h13; aw_addr = 64'h0000_00F0_0000_1000;
    @(negedge clk);                       // AW handshake at previous posedge
    aw_valid = 0;
    chk("wr_w_ready", w_ready, 1);
    chk("wr_aw_ready", aw_ready, 0);
    chk("wr_b_valid_early", b_valid, 0);
    @(negedge clk);                       // W last handshake
    w_valid = 0; w_last = 0;
    chk("wr_b_valid", b_valid, 1);
    chk("wr_b_id", b_id, 5'h13);
    chk("wr_b_resp", b_resp, 2'b11);
    chk("wr_w_ready_off", w_ready, 0);
    @(negedge clk);                       // B handshake
    b_ready = 0;
    chk("wr_done_b_valid", b_valid, 0);
    chk("wr_done_aw_ready", aw_ready, 1);

    // ---- read burst, id 5'h07, len 3
    ar_valid = 1; ar_id = 5'h07; ar_len = 8'd3; r_ready = 1;
    @(negedge clk);
    ar_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_r_valid", r_valid, 1);
      chk("rd_r_id", r_id, 5'h07);
      chk("rd_r_data", r_data, RESP_DATA);
      chk("rd_r_resp", r_resp, 2'b11);
      chk("rd_r_last", r_last, (i == 3) ? 1 : 0);
      chk("rd_ar_ready_busy", ar_ready, 0);
      @(negedge clk);
    end
    chk("rd_done_ar_ready", ar_ready, 1);
    chk("rd_done_r_valid", r_valid, 0);
    r_ready = 0;

    // ---- backpressure, len 1
    ar_valid = 1; ar_id = 5'h0A; ar_len = 8'd1;
    @(negedge clk);
    ar_valid = 0;
    chk("bp_s0_valid", r_valid, 1);
    chk("bp_s0_last", r_last, 0);
    @(negedge clk);                       // stalled cycle
    chk("bp_s1_valid", r_valid, 1);
    chk("bp_s1_last", r_last, 0);
    chk("bp_s1_data", r_data, RESP_DATA);
    r_ready = 1;
    @(negedge clk);                       // beat 1 accepted
    r_ready = 0;
    chk("bp_s2_valid", r_valid, 1);
    chk("bp_s2_last", r_last, 1);
    @(negedge clk);                       // stalled on the last beat
    chk("bp_s3_valid", r_valid, 1);
    chk("bp_s3_last", r_last, 1);
    chk("bp_s3_data", r_data, RESP_DATA);
    chk("bp_s3_id", r_id, 5'h0A);
    r_ready = 1;
    @(negedge clk);                       // beat 2 accepted
    r_ready = 0;
    chk("bp_done_valid", r_valid, 0);
    chk("bp_done_ar_ready", ar_ready, 1);

    // ---- max burst, len 255 -> 256 beats
    ar_valid = 1; ar_id = 5'h1F; ar_len = 8'd255; r_ready = 1;
    @(negedge clk);
    ar_valid = 0;
    for (int i = 0; i < 256; i++) begin
      chk("max_r_valid", r_valid, 1);
      chk("max_r_last", r_last, (i == 255) ? 1 : 0);
      @(negedge clk);
    end
    chk("max_done_r_valid", r_valid, 0);
    chk("max_done_ar_ready", ar_ready, 1);
    r_ready = 0;

    // ---- reset during beat 2 of a len-7 read, with a write also mid-burst
    ar_valid = 1; ar_id = 5'h09; ar_len = 8'd7;
    aw_valid = 1; aw_id = 5'h02;
    @(negedge clk);
    ar_valid = 0; aw_valid = 0;
    r_ready = 1;
    @(negedge clk);                       // beat 1 accepted, beat 2 now presented
    chk("rst_mid_r_valid_before", r_valid, 1);
    chk("rst_mid_w_ready_before", w_ready, 1);
    r_ready = 0;
    rst = 1'b1;
    #1;
    chk("rst_mid_r_valid", r_valid, 0);
    chk("rst_mid_ar_ready", ar_ready, 1);
    chk("rst_mid_aw_ready", aw_ready, 1);
    chk("rst_mid_w_ready", w_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    b_ready = 1; r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    b_ready = 0; r_ready = 0;
`ifdef DECERR_SLAVE_LOG_EN
    chk("log_cnt_after_rst", err_cnt, 0);
    chk("log_addr_after_rst", err_addr, 0);
`endif

    // ---- AW and AR in the same cycle, len 0
    aw_valid = 1; aw_id = 5'h03; aw_addr = 64'h0000_1234_5678_0000;
    ar_valid = 1; ar_id = 5'h04; ar_len = 8'd0; ar_addr = 64'h0000_0ABC_DEF0_0000;
    @(negedge clk);
    aw_valid = 0; ar_valid = 0;
    chk("conc_aw_ready", aw_ready, 0);
    chk("conc_ar_ready", ar_ready, 0);
    chk("conc_w_ready", w_ready, 1);
    chk("conc_r_valid", r_valid, 1);
    chk("conc_r_last", r_last, 1);
    chk("conc_r_id", r_id, 5'h04);
`ifdef DECERR_SLAVE_LOG_EN
    chk("conc_err_cnt", err_cnt, 2);
    chk("conc_err_addr", err_addr, 64'h0000_1234_5678_0000);
`endif
    r_ready = 1;
    @(negedge clk);                       // R handshake
    r_ready = 0;
    chk("conc_r_done", r_valid, 0);
    chk("conc_ar_ready_back", ar_ready, 1);
    chk("conc_b_not_yet", b_valid, 0);
    w_valid = 1; w_last = 1;
    @(negedge clk);                       // W last handshake
    w_valid = 0; w_last = 0;
    chk("conc_b_valid", b_valid, 1);
    chk("conc_b_id", b_id, 5'h03);
    @(negedge clk);                       // B held without ready
    chk("conc_b_hold", b_valid, 1);
    chk("conc_b_hold_id", b_id, 5'h03);
    b_ready = 1;
    @(negedge clk);                       // B handshake
    b_ready = 0;
    chk("conc_b_done", b_valid, 0);
    chk("conc_aw_ready_back", aw_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
